tlc_lamp_monitor: RTL

- Watches the six lamp drives produced by the traffic-light controller and decodes each direction's lamp triple into a phase.
- Checks the phases for safety and sequencing faults and measures how long each phase lasts.
- Sits on the output side of the controller (the consuming end of the lamp interface) and feeds sticky fault flags and phase durations to test/diagnostic logic.

---
 rtl/tlc_lamp_monitor_if.sv | 46 ++++
 rtl/tlc_lamp_monitor.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/tlc_lamp_monitor_if.sv
// ---------------------------------------------------------------------------
// tlc_lamp_monitor_if
//
// Bundle of lamp drives coming from the traffic-light controller plus the
// diagnostic results returned by the lamp monitor.
//
//   GRN1/YLW1/RED1, GRN2/YLW2/RED2 : lamp drives, controller -> monitor
//   ACK                            : clear of sticky flags, diagnostics -> monitor
//   PH1/PH2                        : decoded phase (00 RED, 01 GRN, 10 YLW, 11 ILLEGAL)
//   DUR1/DUR2                      : length of last completed phase per direction
//   CONFLICT/SEQERR/LAMPERR/SHORTY : sticky fault flags
//   FAULT                          : OR of the sticky flags
//
// master : producer side (controller lamps and diagnostic ACK)
// slave  : the monitor
// ---------------------------------------------------------------------------
interface tlc_lamp_monitor_if #(
  parameter int CNT_W = 8
);
  logic             GRN1;
  logic             YLW1;
  logic             RED1;
  logic             GRN2;
  logic             YLW2;
  logic             RED2;
  logic             ACK;
  logic [1:0]       PH1;
  logic [1:0]       PH2;
  logic [CNT_W-1:0] DUR1;
  logic [CNT_W-1:0] DUR2;
  logic             CONFLICT;
  logic             SEQERR;
  logic             LAMPERR;
  logic             SHORTY;
  logic             FAULT;

  modport master (
    output GRN1, YLW1, RED1, GRN2, YLW2, RED2, ACK,
    input  PH1, PH2, DUR1, DUR2, CONFLICT, SEQERR, LAMPERR, SHORTY, FAULT
  );

  modport slave (
    input  GRN1, YLW1, RED1, GRN2, YLW2, RED2, ACK,
    output PH1, PH2, DUR1, DUR2, CONFLICT, SEQERR, LAMPERR, SHORTY, FAULT
  );
endinterface

// File: rtl/tlc_lamp_monitor.sv
// ---------------------------------------------------------------------------
// tlc_lamp_monitor
//
// Watches the six lamp drives of a two-direction traffic-light controller,
// decodes each direction's lamp triple into a phase, checks the phases for
// safety and sequencing faults, and measures the duration of each phase.
//
// Ports:
//   CK    : clock, rising edge
//   CLR   : asynchronous active-high reset
//   lamp  : tlc_lamp_monitor_if.slave
//           inputs  GRN/YLW/RED per direction, ACK
//           outputs PH1/PH2, DUR1/DUR2, CONFLICT, SEQERR, LAMPERR, SHORTY, FAULT
//
// Pipeline:
//   p0 : registered lamp samples plus sample-valid; phases decoded from here
//   p1 : per-direction trackers, durations and sticky flags
// Lamp change -> PHn after one edge, -> DURn/flags after two edges.
// ---------------------------------------------------------------------------
module tlc_lamp_monitor #(
  parameter int CNT_W   = 8,
  parameter int MIN_YLW = 3
) (
  input logic               CK,
  input logic               CLR,
  tlc_lamp_monitor_if.slave lamp
);

  localparam logic [1:0]       PH_RED    = 2'b00;
  localparam logic [1:0]       PH_GRN    = 2'b01;
  localparam logic [1:0]       PH_YLW    = 2'b10;
  localparam logic [1:0]       PH_ILL    = 2'b11;
  localparam logic [CNT_W-1:0] RUN_MAX   = '1;
  localparam logic [CNT_W-1:0] RUN_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_YLW_C = CNT_W'(MIN_YLW);

  // Exactly one lit lamp selects its phase; anything else is ILLEGAL.
  function automatic logic [1:0] decode_phase(input logic [2:0] gyr);
    logic [1:0] ph;
    case (gyr)
      3'b001:  ph = PH_RED;
      3'b100:  ph = PH_GRN;
      3'b010:  ph = PH_YLW;
      default: ph = PH_ILL;
    endcase
    return ph;
  endfunction

  // Only the forward signal cycle RED->GRN->YLW->RED is allowed.
  function automatic logic legal_step(input logic [1:0] from, input logic [1:0] to);
    return ((from == PH_RED) && (to == PH_GRN)) ||
           ((from == PH_GRN) && (to == PH_YLW)) ||
           ((from == PH_YLW) && (to == PH_RED));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == RUN_MAX) ? v : v + RUN_ONE;
  endfunction

  function automatic logic is_lit_phase(input logic [1:0] ph);
    return (ph == PH_GRN) || (ph == PH_YLW);
  endfunction

  // Stage p0: lamp samples
  logic [2:0]            lamp1_p0;
  logic [2:0]            lamp2_p0;
  logic                  vld_p0;

  // Decoded phase per direction, index 0 = direction 1
  logic [1:0][1:0]       ph_p0;

  // Stage p1: trackers and flags
  logic [1:0][1:0]       prev_p1;
  logic [1:0]            pv_p1;
  logic [1:0][CNT_W-1:0] run_p1;
  logic [1:0][CNT_W-1:0] dur_p1;
  logic                  conflict_p1;
  logic                  seqerr_p1;
  logic                  lamperr_p1;
  logic                  shorty_p1;

  // Next-state values
  logic [1:0][1:0]       prev_nx;
  logic [1:0]            pv_nx;
  logic [1:0][CNT_W-1:0] run_nx;
  logic [1:0][CNT_W-1:0] dur_nx;
  logic                  conflict_set;
  logic                  seqerr_set;
  logic                  lamperr_set;
  logic                  shorty_set;

  // ---- state registers ----------------------------------------------------
  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      lamp1_p0    <= '0;
      lamp2_p0    <= '0;
      vld_p0      <= 1'b0;
      prev_p1     <= '0;
      pv_p1       <= '0;
      run_p1      <= '0;
      dur_p1      <= '0;
      conflict_p1 <= 1'b0;
      seqerr_p1   <= 1'b0;
      lamperr_p1  <= 1'b0;
      shorty_p1   <= 1'b0;
    end else begin
      lamp1_p0    <= {lamp.GRN1, lamp.YLW1, lamp.RED1};
      lamp2_p0    <= {lamp.GRN2, lamp.YLW2, lamp.RED2};
      vld_p0      <= 1'b1;
      prev_p1     <= prev_nx;
      pv_p1       <= pv_nx;
      run_p1      <= run_nx;
      dur_p1      <= dur_nx;
      // A set in the same cycle as ACK wins over the clear.
      conflict_p1 <= conflict_set | (conflict_p1 & ~lamp.ACK);
      seqerr_p1   <= seqerr_set   | (seqerr_p1   & ~lamp.ACK);
      lamperr_p1  <= lamperr_set  | (lamperr_p1  & ~lamp.ACK);
      shorty_p1   <= shorty_set   | (shorty_p1   & ~lamp.ACK);
    end
  end

  // ---- phase decode -------------------------------------------------------
  always_comb begin
    ph_p0[0] = PH_ILL;
    ph_p0[1] = PH_ILL;
    if (vld_p0) begin
      ph_p0[0] = decode_phase(lamp1_p0);
      ph_p0[1] = decode_phase(lamp2_p0);
    end
  end

  // ---- tracker next state -------------------------------------------------
  always_comb begin
    prev_nx      = prev_p1;
    pv_nx        = pv_p1;
    run_nx       = run_p1;
    dur_nx       = dur_p1;
    conflict_set = 1'b0;
    seqerr_set   = 1'b0;
    lamperr_set  = 1'b0;
    shorty_set   = 1'b0;

    if (vld_p0) begin
      conflict_set = is_lit_phase(ph_p0[0]) && is_lit_phase(ph_p0[1]);

      for (int d = 0; d < 2; d++) begin
        if (ph_p0[d] == PH_ILL) begin
          // Drop the baseline; the next legal phase restarts tracking
          // without any sequence check.
          lamperr_set = 1'b1;
          pv_nx[d]    = 1'b0;
          run_nx[d]   = '0;
        end else if (!pv_p1[d]) begin
          prev_nx[d] = ph_p0[d];
          pv_nx[d]   = 1'b1;
          run_nx[d]  = RUN_ONE;
        end else if (ph_p0[d] == prev_p1[d]) begin
          run_nx[d] = sat_inc(run_p1[d]);
        end else begin
          dur_nx[d]  = run_p1[d];
          prev_nx[d] = ph_p0[d];
          run_nx[d]  = RUN_ONE;
          if (!legal_step(prev_p1[d], ph_p0[d])) begin
            seqerr_set = 1'b1;
          end
          if ((prev_p1[d] == PH_YLW) && (run_p1[d] < MIN_YLW_C)) begin
            shorty_set = 1'b1;
          end
        end
      end
    end
  end

  // ---- outputs ------------------------------------------------------------
  always_comb begin
    lamp.PH1      = ph_p0[0];
    lamp.PH2      = ph_p0[1];
    lamp.DUR1     = dur_p1[0];
    lamp.DUR2     = dur_p1[1];
    lamp.CONFLICT = conflict_p1;
    lamp.SEQERR   = seqerr_p1;
    lamp.LAMPERR  = lamperr_p1;
    lamp.SHORTY   = shorty_p1;
    lamp.FAULT    = conflict_p1 | seqerr_p1 | lamperr_p1 | shorty_p1;
  end

endmodule
